gate_sweep_ctrl: RTL and testbench

- Sequential self-checking controller for small combinational gates (NOR, NAND, De Morgan equivalents).
- Drives the gate-under-test inputs through every combination in ascending binary order, waits a programmable settle time per row, and samples the gate output.
- Compares each sample against a parameterised expected truth table and reports per-row strobes, a failure bitmap, an error count and a final pass flag.
- Replaces hand-written truth-table benches and serves as an on-chip BIST sequencer for the gate datapath.

---
 rtl/gate_sweep_ctrl_pkg.sv | 18 +
 rtl/gate_sweep_ctrl_settle_timer.sv | 28 ++
 rtl/gate_sweep_ctrl.sv | 153 +++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_sweep_ctrl_pkg.sv
// Shared state encoding and stock truth tables for the gate sweep controller.
// Purely declarative; no latency or flow-control implications.
package gate_sweep_defs;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } sweepState_t;

  // Bit i is the expected gate output when stim == i, with stim = {A,B}.
  localparam logic [3:0] TT_NOR2  = 4'b0001;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_AND2  = 4'b1000;

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Loadable down-counter that flags when the settle interval has elapsed.
// Load takes effect next edge; zero is combinational from the count; no backpressure.
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] loadVal,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadVal;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Walks a gate through every input combination, samples it after a settle delay and scores it.
// Latency 2**N_IN*(SETTLE_CYCLES+1)+1 cycles start-to-done; start ignored while busy, abort cancels.
module gate_sweep_ctrl
  import gate_sweep_defs::*;
#(
  parameter int                  N_IN          = 2,
  parameter int                  SETTLE_CYCLES = 1,
  parameter logic [2**N_IN-1:0]  EXPECTED      = TT_NOR2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [N_IN-1:0]   stim,
  input  logic              dut_out,
  output logic              busy,
  output logic              row_strobe,
  output logic [N_IN-1:0]   row_idx,
  output logic              row_ok,
  output logic [2**N_IN-1:0] fail_vec,
  output logic [N_IN:0]     err_count,
  output logic              done,
  output logic              pass
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1) begin : gBadSettle
    $error("gate_sweep_ctrl: SETTLE_CYCLES must be at least 1");
  end
  if ((N_IN < 1) || (N_IN > 4)) begin : gBadWidth
    $error("gate_sweep_ctrl: N_IN must be in 1..4");
  end

  sweepState_t state, stateNxt;
  logic [N_IN-1:0]    idx, idxNxt, stimNxt, rowIdxNxt;
  logic [2**N_IN-1:0] failVecNxt;
  logic [N_IN:0]      errCountNxt;
  logic               rowStrobeNxt, rowOkNxt, doneNxt, passNxt;
  logic               sampleOk, tmrLoad, tmrEn, tmrZero;

  settle_timer #(.W(CW)) uTimer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmrLoad),
    .en      (tmrEn),
    .loadVal (RELOAD),
    .zero    (tmrZero)
  );

  assign busy     = (state == S_SETTLE) || (state == S_SAMPLE);
  assign sampleOk = (dut_out == EXPECTED[idx]);

  always_comb begin
    stateNxt     = state;
    idxNxt       = idx;
    stimNxt      = stim;
    rowStrobeNxt = 1'b0;
    rowIdxNxt    = row_idx;
    rowOkNxt     = row_ok;
    failVecNxt   = fail_vec;
    errCountNxt  = err_count;
    doneNxt      = 1'b0;
    passNxt      = pass;
    tmrLoad      = 1'b0;
    tmrEn        = 1'b0;

    case (state)
      S_IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          stateNxt    = S_SETTLE;
          idxNxt      = '0;
          stimNxt     = '0;
          failVecNxt  = '0;
          errCountNxt = '0;
          passNxt     = 1'b0;
          tmrLoad     = 1'b1;
        end
      end
      S_SETTLE: begin
        if (abort) begin
          stateNxt = S_IDLE;
          stimNxt  = '0;
          passNxt  = 1'b0;
        end else if (tmrZero) begin
          stateNxt = S_SAMPLE;
        end else begin
          tmrEn = 1'b1;
        end
      end
      S_SAMPLE: begin
        if (abort) begin
          stateNxt = S_IDLE;
          stimNxt  = '0;
          passNxt  = 1'b0;
        end else begin
          rowStrobeNxt = 1'b1;
          rowIdxNxt    = idx;
          rowOkNxt     = sampleOk;
          if (!sampleOk) begin
            failVecNxt[idx] = 1'b1;
            errCountNxt     = err_count + 1'b1;
          end
          if (idx == '1) begin
            stateNxt = S_DONE;
            stimNxt  = '0;
          end else begin
            stateNxt = S_SETTLE;
            idxNxt   = idx + 1'b1;
            stimNxt  = idx + 1'b1;
            tmrLoad  = 1'b1;
          end
        end
      end
      S_DONE: begin
        stateNxt = S_IDLE;
        stimNxt  = '0;
        doneNxt  = 1'b1;
        passNxt  = (err_count == '0);
      end
      default: stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      stim       <= '0;
      row_strobe <= 1'b0;
      row_idx    <= '0;
      row_ok     <= 1'b0;
      fail_vec   <= '0;
      err_count  <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= stateNxt;
      idx        <= idxNxt;
      stim       <= stimNxt;
      row_strobe <= rowStrobeNxt;
      row_idx    <= rowIdxNxt;
      row_ok     <= rowOkNxt;
      fail_vec   <= failVecNxt;
      err_count  <= errCountNxt;
      done       <= doneNxt;
      pass       <= passNxt;
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomised scoreboard bench for gate_sweep_ctrl driving a behavioural gate with settle glitches.
module tb_gate_sweep_ctrl;

  localparam int N      = 2;
  localparam int SC     = 3;
  localparam int ROWS   = 4;
  localparam int ROWCYC = SC + 1;
  localparam int SWEEP  = ROWS * ROWCYC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic dut_out;
  logic [N-1:0] stim, row_idx;
  logic busy, row_strobe, row_ok, done, pass;
  logic [ROWS-1:0] fail_vec;
  logic [N:0] err_count;

  int checks = 0;
  int failures = 0;
  int cycCnt = 0;
  int mode = 0;
  logic [3:0] rndTable = 4'b0;
  logic glitch = 1'b0;
  bit lastPass = 1'b0;

  typedef struct {
    bit         isDone;
    int         cyc;
    int         idx;
    bit         ok;
    int         errs;
    logic [3:0] fv;
    bit         pass;
  } ev_t;
  ev_t sbQ[$];

  always #5 clk = ~clk;

  gate_sweep_ctrl #(.N_IN(N), .SETTLE_CYCLES(SC), .EXPECTED(4'b0001)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .stim(stim),
    .dut_out(dut_out), .busy(busy), .row_strobe(row_strobe), .row_idx(row_idx),
    .row_ok(row_ok), .fail_vec(fail_vec), .err_count(err_count), .done(done), .pass(pass)
  );

  // Reference: a 2-input NOR with stim = {A,B}.
  function automatic logic refNor(input int s);
    logic a, b;
    a = ((s >> 1) & 1) != 0;
    b = (s & 1) != 0;
    return !(a | b);
  endfunction

  // Gate actually wired to the controller: 0 NOR, 1 OR, 2 stuck-at-0, 3 arbitrary table.
  function automatic logic gateModel(input int m, input int s, input logic [3:0] t);
    case (m)
      0: return refNor(s);
      1: return s != 0;
      2: return 1'b0;
      default: return t[s];
    endcase
  endfunction

  assign dut_out = gateModel(mode, int'(stim), rndTable) ^ glitch;

  always @(posedge clk) cycCnt <= cycCnt + 1;

  // Glitches only in the early part of each new stim value, well before any sample point.
  initial begin : glitchGen
    int age;
    logic [N-1:0] prevStim;
    age = 100;
    prevStim = '0;
    forever begin
      @(posedge clk);
      #1;
      if (stim != prevStim) age = 0;
      else if (age < 100) age++;
      glitch = (age < SC - 1) ? 1'($urandom % 2) : 1'b0;
      prevStim = stim;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cycCnt);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (row_strobe || done)) begin
      if (sbQ.size() == 0) begin
        chk("unexpected_event", {30'd0, row_strobe, done}, 32'd0);
      end else begin
        ev_t ev;
        ev = sbQ.pop_front();
        if (ev.isDone) begin
          chk("done_pulse", done, 1);
          chk("done_cycle", cycCnt, ev.cyc);
          chk("done_err_count", err_count, ev.errs);
          chk("done_fail_vec", fail_vec, ev.fv);
          chk("done_pass", pass, ev.pass);
        end else begin
          chk("row_strobe", row_strobe, 1);
          chk("row_cycle", cycCnt, ev.cyc);
          chk("row_idx", row_idx, ev.idx);
          chk("row_ok", row_ok, ev.ok);
        end
      end
    end
  end

  task automatic chkAllZero(input string tag);
    chk({tag, "_stim"}, stim, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_row_strobe"}, row_strobe, 0);
    chk({tag, "_row_idx"}, row_idx, 0);
    chk({tag, "_row_ok"}, row_ok, 0);
    chk({tag, "_fail_vec"}, fail_vec, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
  endtask

  // One sweep; abortAt/resetAt are cycle offsets after the accept edge (-1 = none).
  task automatic runSweep(input int m, input int abortAt, input int resetAt, input bit restarts);
    int a, errs;
    logic [3:0] fv;
    bit ok, killed, full;
    mode = m;
    @(negedge clk);
    start = 1'b1;
    a = cycCnt + 1;
    errs = 0;
    fv = '0;
    full = !((abortAt >= 0 && abortAt < SWEEP) || resetAt >= 0);
    for (int r = 0; r < ROWS; r++) begin
      int sc;
      ev_t ev;
      sc = r * ROWCYC + SC;
      if (!full && ((abortAt >= 0 && sc >= abortAt) || (resetAt >= 0 && sc >= resetAt))) continue;
      ok = (gateModel(m, r, rndTable) == refNor(r));
      if (!ok) begin
        errs++;
        fv[r] = 1'b1;
      end
      ev.isDone = 0; ev.cyc = a + (r + 1) * ROWCYC; ev.idx = r; ev.ok = ok;
      ev.errs = 0; ev.fv = '0; ev.pass = 0;
      sbQ.push_back(ev);
    end
    if (full) begin
      ev_t ev;
      ev.isDone = 1; ev.cyc = a + SWEEP + 1; ev.idx = 0; ev.ok = 0;
      ev.errs = errs; ev.fv = fv; ev.pass = (errs == 0);
      sbQ.push_back(ev);
      lastPass = (errs == 0);
    end else begin
      lastPass = 0;
    end
    killed = 0;
    for (int j = 0; j <= SWEEP && !killed; j++) begin
      @(negedge clk);
      start = restarts ? 1'($urandom % 2) : 1'b0;
      chk("stim_trace", stim, (j < SWEEP) ? j / ROWCYC : 0);
      chk("busy_trace", busy, (j < SWEEP) ? 1 : 0);
      abort = (j == abortAt);
      if (j == abortAt && abortAt < SWEEP) begin
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_stim", stim, 0);
        chk("abort_busy", busy, 0);
        chk("abort_pass", pass, 0);
        chk("abort_done", done, 0);
        chk("abort_err_count", err_count, errs);
        chk("abort_fail_vec", fail_vec, fv);
        killed = 1;
      end
      if (j == resetAt) begin
        #2 reset = 1'b1;
        #1 chkAllZero("midreset");
        sbQ.delete();
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        killed = 1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("after_pass", pass, lastPass);
    repeat (2) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
    end
    chk("missing_events", sbQ.size(), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chkAllZero("reset");
    reset = 1'b0;
    @(negedge clk);
    chkAllZero("post_reset");

    runSweep(0, -1, -1, 0);
    chk("nor_err_count", err_count, 0);
    chk("nor_fail_vec", fail_vec, 4'b0000);
    runSweep(1, -1, -1, 0);
    chk("or_err_count", err_count, 4);
    chk("or_fail_vec", fail_vec, 4'b1111);
    runSweep(2, -1, -1, 0);
    chk("stuck0_err_count", err_count, 1);
    chk("stuck0_fail_vec", fail_vec, 4'b0001);
    runSweep(0, -1, -1, 1);
    runSweep(1, 2 * ROWCYC + 1, -1, 0);
    runSweep(0, SWEEP, -1, 0);

    // abort and start together in IDLE: no sweep
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) begin
      chk("abort_start_busy", busy, 0);
      chk("abort_start_pass_hold", pass, 1);
      @(negedge clk);
    end

    runSweep(0, -1, 2 * ROWCYC + SC, 0);
    runSweep(0, -1, -1, 0);

    for (int k = 0; k < 12; k++) begin
      int ab;
      rndTable = 4'($urandom);
      ab = ($urandom % 3 == 0) ? int'($urandom_range(0, SWEEP)) : -1;
      runSweep(int'($urandom % 4), ab, -1, 1'($urandom % 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
